instr_load_arbiter: RTL and testbench

// - Shares the write port of instr_register between NUM_REQ requesters.
// - Uses round-robin arbitration with a valid/ready handshake.
// - Auto-generates write_pointer and read_pointer as a circular queue, with occupancy tracking.
// - Provides a FLUSH sequence that rewrites every entry to opcode ZERO with zero operands.
// - Sits directly in front of instr_register; its outputs connect 1:1 to that block's load/pointer inputs.

---
 rtl/instr_load_arbiter_if.sv | 41 ++++
 rtl/instr_load_arbiter.sv | 133 +++++++++++++
 tb/tb_instr_load_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_load_arbiter_if.sv
// Requester, consumer and instr_register-facing signals of instr_load_arbiter.
// Operands are two's complement; every bus is carried as plain logic.
interface instr_load_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 32,
  parameter int OPC_W   = 4,
  parameter int OPR_W   = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*OPC_W-1:0] req_opcode;
  logic [NUM_REQ*OPR_W-1:0] req_operand_a;
  logic [NUM_REQ*OPR_W-1:0] req_operand_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rd_next;
  logic                     flush_req;
  logic                     load_en;
  logic [OPC_W-1:0]         opcode;
  logic [OPR_W-1:0]         operand_a;
  logic [OPR_W-1:0]         operand_b;
  logic [ADDR_W-1:0]        write_pointer;
  logic [ADDR_W-1:0]        read_pointer;
  logic [ADDR_W:0]          count;
  logic                     full;
  logic                     empty;
  logic                     busy;
  logic                     flush_done;

  modport slave (
    input  req_valid, req_opcode, req_operand_a, req_operand_b, rd_next, flush_req,
    output req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
           read_pointer, count, full, empty, busy, flush_done
  );

  modport master (
    output req_valid, req_opcode, req_operand_a, req_operand_b, rd_next, flush_req,
    input  req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
           read_pointer, count, full, empty, busy, flush_done
  );
endinterface

// File: rtl/instr_load_arbiter.sv
// Round-robin loader for instr_register with circular pointers and a DEPTH-cycle FLUSH.
// Write appears 1 cycle after the handshake; ready drops when full, flushing or flush_req.
module instr_load_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 32,
  parameter int OPC_W   = 4,
  parameter int OPR_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_load_arbiter_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [RR_W-1:0]     rr_last, win, cand;
  logic                found;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, flush_idx, wp_q;
  logic [ADDR_W:0]     cnt;
  logic                busy_q, done_q, load_q;
  logic [OPC_W-1:0]    opc_q;
  logic [OPR_W-1:0]    a_q, b_q;
  logic                full, empty, flush_go, can_grant, transfer, do_rd, flush_last;

  assign full       = (cnt == (ADDR_W+1)'(DEPTH));
  assign empty      = (cnt == '0);
  assign flush_last = (flush_idx == ADDR_W'(DEPTH-1));

  // busy_q still covers the final flush write cycle, after the FSM is back in ARB
  assign flush_go  = (state_q == ARB) && !busy_q && bus.flush_req;
  assign can_grant = (state_q == ARB) && !busy_q && !bus.flush_req && !full && found;
  assign do_rd     = (state_q == ARB) && !busy_q && !bus.flush_req && bus.rd_next && !empty;

  always_comb begin
    found = 1'b0;
    win   = rr_last;
    cand  = rr_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = RR_W'((int'(rr_last) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign bus.req_ready = can_grant ? (NUM_REQ'(1) << win) : '0;
  assign transfer      = |(bus.req_valid & bus.req_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (flush_go) state_d = FLUSH;
      FLUSH:   if (flush_last) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last   <= RR_W'(NUM_REQ-1);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      flush_idx <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wp_q      <= '0;
    end else if (state_q == FLUSH) begin
      load_q    <= 1'b1;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wp_q      <= flush_idx;
      flush_idx <= flush_idx + ADDR_W'(1);
      busy_q    <= 1'b1;
      done_q    <= flush_last;
      if (flush_last) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end
    end else if (flush_go) begin
      load_q    <= 1'b1;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wp_q      <= '0;
      flush_idx <= ADDR_W'(1);
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      load_q <= transfer;
      if (transfer) begin
        opc_q   <= bus.req_opcode[win*OPC_W +: OPC_W];
        a_q     <= bus.req_operand_a[win*OPR_W +: OPR_W];
        b_q     <= bus.req_operand_b[win*OPR_W +: OPR_W];
        wp_q    <= wr_ptr;
        wr_ptr  <= wr_ptr + ADDR_W'(1);
        rr_last <= win;
      end
      if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (transfer && !do_rd)      cnt <= cnt + (ADDR_W+1)'(1);
      else if (!transfer && do_rd) cnt <= cnt - (ADDR_W+1)'(1);
    end
  end

  assign bus.load_en       = load_q;
  assign bus.opcode        = opc_q;
  assign bus.operand_a     = a_q;
  assign bus.operand_b     = b_q;
  assign bus.write_pointer = wp_q;
  assign bus.read_pointer  = rd_ptr;
  assign bus.count         = cnt;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.busy          = busy_q;
  assign bus.flush_done    = done_q;
endmodule

// File: tb/tb_instr_load_arbiter.sv
// Scoreboard bench for instr_load_arbiter: expected writes are queued at each handshake/flush and popped on load_en.
module tb_instr_load_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 32;
  localparam int OPC_W   = 4;
  localparam int OPR_W   = 32;
  localparam int ADDR_W  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_load_arbiter_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .OPC_W(OPC_W), .OPR_W(OPR_W)) ifc();

  instr_load_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .OPC_W(OPC_W), .OPR_W(OPR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  typedef struct {
    logic [OPC_W-1:0]  opc;
    logic [OPR_W-1:0]  a;
    logic [OPR_W-1:0]  b;
    logic [ADDR_W-1:0] wp;
    bit                fl;
    bit                done;
  } wr_t;

  wr_t               sb[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                m_count;
  int                m_rr;
  logic [ADDR_W-1:0] m_wr, m_rd;
  logic [NUM_REQ-1:0] last_rdy;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [OPC_W-1:0] o, input logic [OPR_W-1:0] a,
                         input logic [OPR_W-1:0] b);
    ifc.req_opcode[i*OPC_W +: OPC_W]    = o;
    ifc.req_operand_a[i*OPR_W +: OPR_W] = a;
    ifc.req_operand_b[i*OPR_W +: OPR_W] = b;
  endtask

  function automatic logic [NUM_REQ-1:0] model_grant(input bit blocked);
    if (blocked || ifc.flush_req || m_count >= DEPTH) return '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx = (m_rr + k) % NUM_REQ;
      if (ifc.req_valid[idx]) return NUM_REQ'(1) << idx;
    end
    return '0;
  endfunction

  // One clock: check outputs at negedge, then advance the model on the rising edge.
  task automatic cycle();
    wr_t e;
    bit blocked, wr, rd;
    logic [NUM_REQ-1:0] g;
    int w;
    @(negedge clk);
    blocked = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("load_en", ifc.load_en, 1);
      chk("opcode", ifc.opcode, e.opc);
      chk("operand_a", ifc.operand_a, e.a);
      chk("operand_b", ifc.operand_b, e.b);
      chk("write_pointer", ifc.write_pointer, e.wp);
      chk("flush_done", ifc.flush_done, e.done);
      blocked = e.fl;
      if (e.done) begin
        m_count = 0;
        m_wr    = '0;
        m_rd    = '0;
      end
    end else begin
      chk("load_en_idle", ifc.load_en, 0);
      chk("flush_done_idle", ifc.flush_done, 0);
    end
    chk("busy", ifc.busy, blocked);
    chk("count", ifc.count, m_count);
    chk("read_pointer", ifc.read_pointer, m_rd);
    chk("full", ifc.full, m_count == DEPTH);
    chk("empty", ifc.empty, m_count == 0);
    g = model_grant(blocked);
    chk("req_ready", ifc.req_ready, g);
    last_rdy = ifc.req_ready;
    @(posedge clk);
    wr = (g != '0);
    if (wr) begin
      w = 0;
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) w = i;
      sb.push_back('{ifc.req_opcode[w*OPC_W +: OPC_W], ifc.req_operand_a[w*OPR_W +: OPR_W],
                     ifc.req_operand_b[w*OPR_W +: OPR_W], m_wr, 1'b0, 1'b0});
      m_wr++;
      m_rr = w;
    end
    rd = !blocked && !ifc.flush_req && ifc.rd_next && (m_count > 0);
    if (rd) m_rd++;
    m_count = m_count + int'(wr) - int'(rd);
    if (!blocked && ifc.flush_req)
      for (int i = 0; i < DEPTH; i++)
        sb.push_back('{'0, '0, '0, ADDR_W'(i), 1'b1, (i == DEPTH-1)});
    #1;
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    ifc.req_valid     = '0;
    ifc.req_opcode    = '0;
    ifc.req_operand_a = '0;
    ifc.req_operand_b = '0;
    ifc.rd_next       = 1'b0;
    ifc.flush_req     = 1'b0;
    sb.delete();
    m_count = 0;
    m_wr    = '0;
    m_rd    = '0;
    m_rr    = NUM_REQ - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] rr_seq [4];
    rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b01; rr_seq[3] = 2'b10;

    // Reset state
    do_reset();
    chk("rst_load_en", ifc.load_en, 0);
    chk("rst_opcode", ifc.opcode, 0);
    chk("rst_operand_a", ifc.operand_a, 0);
    chk("rst_operand_b", ifc.operand_b, 0);
    chk("rst_write_pointer", ifc.write_pointer, 0);
    chk("rst_read_pointer", ifc.read_pointer, 0);
    chk("rst_count", ifc.count, 0);
    chk("rst_full", ifc.full, 0);
    chk("rst_empty", ifc.empty, 1);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_flush_done", ifc.flush_done, 0);
    chk("rst_req_ready", ifc.req_ready, 0);
    cycle();

    // Round-robin fairness with both requesters asserting
    for (int i = 0; i < NUM_REQ; i++) set_req(i, OPC_W'(i + 1), OPR_W'(100 + i), OPR_W'(200 + i));
    ifc.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_grant_seq", last_rdy, rr_seq[i]);
    end
    ifc.req_valid = '0;
    cycle();
    chk("rr_count4", ifc.count, 4);

    // Data path, negative operand
    set_req(1, 4'd3, 32'd5, 32'hFFFF_FFFE);
    ifc.req_valid = 2'b10;
    cycle();
    ifc.req_valid = '0;
    cycle();
    chk("dp_operand_b", ifc.operand_b, 64'h0000_0000_FFFF_FFFE);
    cycle();

    // Full and write-pointer wrap
    do_reset();
    ifc.req_valid = 2'b01;
    for (int i = 0; i < 40 && m_count < DEPTH; i++) begin
      set_req(0, OPC_W'(i), OPR_W'(i * 7), OPR_W'(-i));
      cycle();
    end
    repeat (3) cycle();
    chk("full_flag", ifc.full, 1);
    ifc.rd_next = 1'b1;
    cycle();
    ifc.rd_next = 1'b0;
    set_req(0, 4'hA, 32'hDEAD_BEEF, 32'h1234_5678);
    cycle();
    ifc.req_valid = '0;
    repeat (3) cycle();

    // Simultaneous write and read, then reads past empty
    do_reset();
    ifc.req_valid = 2'b01;
    repeat (3) cycle();
    ifc.rd_next = 1'b1;
    cycle();
    ifc.req_valid = '0;
    repeat (5) cycle();
    ifc.rd_next = 1'b0;
    repeat (2) cycle();

    // Flush with count=5; rd_next, flush_req and valids ignored while busy
    do_reset();
    set_req(0, 4'h7, 32'h11, 32'h22);
    set_req(1, 4'h9, 32'h33, 32'h44);
    ifc.req_valid = 2'b01;
    repeat (5) cycle();
    ifc.req_valid = '0;
    ifc.flush_req = 1'b1;
    cycle();
    ifc.flush_req = 1'b0;
    ifc.rd_next   = 1'b1;
    ifc.req_valid = 2'b11;
    for (int i = 0; i < DEPTH + 2; i++) begin
      ifc.flush_req = (i == 10);
      cycle();
    end
    ifc.rd_next   = 1'b0;
    ifc.req_valid = '0;
    repeat (2) cycle();

    // Reset in the middle of a flush
    ifc.flush_req = 1'b1;
    cycle();
    ifc.flush_req = 1'b0;
    repeat (10) cycle();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_load_en", ifc.load_en, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_count", ifc.count, 0);
    chk("mid_rst_write_pointer", ifc.write_pointer, 0);
    chk("mid_rst_flush_done", ifc.flush_done, 0);
    do_reset();
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
